// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared fetch-state encoding and line geometry constants for the VGA path
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_t;

    localparam int          LINE_NUM_W   = 10;
    localparam int          WORD_CNT_W   = 11;
    localparam logic [10:0] WORDS_MODE0  = 11'd640;
    localparam logic [10:0] WORDS_MODE1  = 11'd1024;

    // Words per scan line for the selected video mode.
    function automatic logic [10:0] line_words(input logic mode);
        return mode ? WORDS_MODE1 : WORDS_MODE0;
    endfunction

endpackage

// File: rtl/pulse_sync_rise.sv
// rtl/pulse_sync_rise.sv - two-flop synchronizer with registered rising-edge detect
module pulse_sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    // sh[1:0] is the metastability chain, sh[2] holds the previous synced level
    logic [2:0] sh;

    // Shift the asynchronous level through the chain and the edge register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= 3'b000;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/vga_line_fetch.sv
// rtl/vga_line_fetch.sv - burst-fetches a frame line into ping-pong line buffer A or B; optional VGA_FETCH_UNDERRUN_CNT_EN adds underrun_cnt
module vga_line_fetch
    import vga_pkg::*;
#(
    parameter int LINE_STRIDE = 1024,
    parameter int BURST_LEN   = 8,
    parameter int AW          = 24
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          vga_mode,
    input  logic [AW-1:0] frame_base,
    input  logic          read_buff_req,
    input  logic          read_buff_A_B,
    input  logic [9:0]    read_buff_addr,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_rd_addr,
    input  logic          mem_rd_ack,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_rdata_valid,
    output logic [9:0]    buff_writeA_addr,
    output logic [15:0]   buff_writeA_data,
    output logic          buff_writeA_en,
    output logic [9:0]    buff_writeB_addr,
    output logic [15:0]   buff_writeB_data,
    output logic          buff_writeB_en,
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    output logic [15:0]   underrun_cnt,
`endif
    output logic          busy,
    output logic          underrun
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    fetch_state_t             state;
    logic                     start;

    // Line currently being fetched
    logic                     cur_ab;
    logic [LINE_NUM_W-1:0]    cur_line;
    logic                     cur_mode;
    logic [AW-1:0]            cur_base;
    logic [WORD_CNT_W-1:0]    word_idx;
    logic [BW-1:0]            beat;

    // Line requested while busy, fetched once the current burst drains
    logic                     pend_valid;
    logic                     pend_ab;
    logic [LINE_NUM_W-1:0]    pend_line;
    logic                     pend_mode;
    logic [AW-1:0]            pend_base;

    // Line to restart on at burst completion: a same-cycle start beats the latched one
    logic                     take_ab;
    logic [LINE_NUM_W-1:0]    take_line;
    logic                     take_mode;
    logic [AW-1:0]            take_base;

    logic                     wr_strobe;
    logic                     burst_done;
    logic [WORD_CNT_W-1:0]    word_next;

    function automatic logic [AW-1:0] burst_addr(input logic [AW-1:0] base,
                                                 input logic [LINE_NUM_W-1:0] line,
                                                 input logic [WORD_CNT_W-1:0] idx);
        return base + AW'(line) * AW'(LINE_STRIDE) + AW'(idx);
    endfunction

    pulse_sync_rise u_req_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .din   (read_buff_req),
        .rise  (start)
    );

    assign take_ab    = start ? read_buff_A_B  : pend_ab;
    assign take_line  = start ? read_buff_addr : pend_line;
    assign take_mode  = start ? vga_mode       : pend_mode;
    assign take_base  = start ? frame_base     : pend_base;

    assign busy       = (state != ST_IDLE);
    assign underrun   = start & busy;
    assign wr_strobe  = (state == ST_DATA) & mem_rdata_valid;
    assign burst_done = wr_strobe & (beat == BEAT_LAST);
    assign word_next  = word_idx + 11'd1;

    // Data strobes land in the selected buffer in the same cycle; idle outputs are held at zero
    assign buff_writeA_en   = wr_strobe & ~cur_ab;
    assign buff_writeA_addr = buff_writeA_en ? word_idx[9:0] : 10'd0;
    assign buff_writeA_data = buff_writeA_en ? mem_rdata : 16'd0;
    assign buff_writeB_en   = wr_strobe & cur_ab;
    assign buff_writeB_addr = buff_writeB_en ? word_idx[9:0] : 10'd0;
    assign buff_writeB_data = buff_writeB_en ? mem_rdata : 16'd0;

    // Fetch sequencer: request a burst, count its data strobes, then advance, restart or finish
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            cur_ab      <= 1'b0;
            cur_line    <= '0;
            cur_mode    <= 1'b0;
            cur_base    <= '0;
            word_idx    <= '0;
            beat        <= '0;
            pend_valid  <= 1'b0;
            pend_ab     <= 1'b0;
            pend_line   <= '0;
            pend_mode   <= 1'b0;
            pend_base   <= '0;
            mem_rd_req  <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_ab      <= read_buff_A_B;
                        cur_line    <= read_buff_addr;
                        cur_mode    <= vga_mode;
                        cur_base    <= frame_base;
                        word_idx    <= '0;
                        beat        <= '0;
                        mem_rd_req  <= 1'b1;
                        mem_rd_addr <= burst_addr(frame_base, read_buff_addr, '0);
                        state       <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (mem_rd_req && mem_rd_ack) begin
                        // The burst is committed; a racing start must wait for it to drain
                        mem_rd_req <= 1'b0;
                        beat       <= '0;
                        state      <= ST_DATA;
                        if (start) begin
                            pend_valid <= 1'b1;
                            pend_ab    <= read_buff_A_B;
                            pend_line  <= read_buff_addr;
                            pend_mode  <= vga_mode;
                            pend_base  <= frame_base;
                        end
                    end else if (start) begin
                        // Abort the unacknowledged request; re-raise next cycle with the new address
                        cur_ab      <= read_buff_A_B;
                        cur_line    <= read_buff_addr;
                        cur_mode    <= vga_mode;
                        cur_base    <= frame_base;
                        word_idx    <= '0;
                        mem_rd_req  <= 1'b0;
                        mem_rd_addr <= burst_addr(frame_base, read_buff_addr, '0);
                    end else if (!mem_rd_req) begin
                        mem_rd_req <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (start) begin
                        pend_valid <= 1'b1;
                        pend_ab    <= read_buff_A_B;
                        pend_line  <= read_buff_addr;
                        pend_mode  <= vga_mode;
                        pend_base  <= frame_base;
                    end
                    if (wr_strobe) begin
                        word_idx <= word_next;
                        beat     <= beat + 1'b1;
                    end
                    if (burst_done) begin
                        if (start || pend_valid) begin
                            cur_ab      <= take_ab;
                            cur_line    <= take_line;
                            cur_mode    <= take_mode;
                            cur_base    <= take_base;
                            word_idx    <= '0;
                            pend_valid  <= 1'b0;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= burst_addr(take_base, take_line, '0);
                            state       <= ST_REQ;
                        end else if (word_next == line_words(cur_mode)) begin
                            state <= ST_IDLE;
                        end else begin
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= burst_addr(cur_base, cur_line, word_next);
                            state       <= ST_REQ;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    // Saturating tally of underrun pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underrun_cnt <= 16'd0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
